// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package arm_mem_pkg;

    localparam int unsigned STARVE_MAX_DEFAULT = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IBUSY = 2'b01,
        DBUSY = 2'b10
    } arbState_t;

    // Command presented to the shared memory port
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } memCmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port,
// with a bounded-starvation priority for the data port.
module mem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic [DATA_W-1:0] IRdata,
    output logic              IReady,

    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWdata,
    output logic [DATA_W-1:0] DRdata,
    output logic              DReady,

    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWdata,
    input  logic [DATA_W-1:0] MemRdata,
    input  logic              MemAck
);

    localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    arbState_t        state;
    logic [CNT_W-1:0] starveCnt;
    memCmd_t          cmd;

    logic iElig;
    logic dElig;
    logic dWins;
    logic iWins;

    // A requester whose Ready is high this cycle still shows its old request
    assign iElig = IReq && !IReady;
    assign dElig = DReq && !DReady;
    assign dWins = dElig && (!iElig || (starveCnt < CNT_W'(STARVE_MAX)));
    assign iWins = iElig && !dWins;

    assign MemWe    = cmd.we;
    assign MemAddr  = cmd.addr;
    assign MemWdata = cmd.wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            starveCnt <= '0;
            cmd       <= '0;
            MemReq    <= 1'b0;
            IReady    <= 1'b0;
            DReady    <= 1'b0;
            IRdata    <= '0;
            DRdata    <= '0;
        end else begin
            IReady <= 1'b0;
            DReady <= 1'b0;
            case (state)
                IDLE: begin
                    if (dWins) begin
                        state  <= DBUSY;
                        MemReq <= 1'b1;
                        cmd    <= '{we: DWe, addr: DAddr, wdata: DWdata};
                        if (IReq && (starveCnt < CNT_W'(STARVE_MAX))) begin
                            starveCnt <= starveCnt + CNT_W'(1);
                        end
                    end else if (iWins) begin
                        state     <= IBUSY;
                        MemReq    <= 1'b1;
                        cmd.we    <= 1'b0;
                        cmd.addr  <= IAddr;
                        starveCnt <= '0;
                    end
                end
                IBUSY: begin
                    if (MemAck) begin
                        IRdata <= MemRdata;
                        IReady <= 1'b1;
                        MemReq <= 1'b0;
                        state  <= IDLE;
                    end
                end
                DBUSY: begin
                    if (MemAck) begin
                        if (!cmd.we) begin
                            DRdata <= MemRdata;
                        end
                        DReady <= 1'b1;
                        MemReq <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
